// File: rtl/collatz_range.sv
// Sweeps a contiguous range of start values through one Collatz iterator and
// records the step count to reach 1 for each value in a host-readable RAM.
module collatz_range #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  start_n,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              finished,
  output logic              it_go,
  output logic [WIDTH-1:0]  it_n,
  input  logic [WIDTH-1:0]  it_dout,
  input  logic              it_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] STORE = 2'd3;

  localparam logic [CNT_W-1:0]  ABANDONED  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  STEP_LIMIT = CNT_W'(MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]  STEP_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0]  VAL_ONE    = WIDTH'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

  logic [1:0]        state;
  logic [WIDTH-1:0]  cur;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt_r;
  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  steps_r;
  logic [ADDR_W:0]   last_idx;
  logic [WIDTH-1:0]  next_cur;
  logic              is_last;

  logic [CNT_W-1:0]  mem [0:(1 << ADDR_W) - 1];

  // Only it_done matters; the sequence values themselves are not recorded.
  logic unused_dout;
  assign unused_dout = ^it_dout;

  assign last_idx = cnt_r - CNT_ONE;
  assign is_last  = ({1'b0, idx} == last_idx);
  assign next_cur = cur + VAL_ONE;

  // it_go and it_n are registered on entry to LOAD so the pulse lines up with that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur      <= '0;
      idx      <= '0;
      cnt_r    <= '0;
      step_cnt <= '0;
      steps_r  <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
      it_go    <= 1'b0;
      it_n     <= '0;
    end else begin
      it_go    <= 1'b0;
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              cur   <= start_n;
              idx   <= '0;
              cnt_r <= count;
              it_n  <= start_n;
              it_go <= 1'b1;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              finished <= 1'b1;
            end
          end
        end
        LOAD: begin
          step_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (it_done) begin
            steps_r <= step_cnt;
            state   <= STORE;
          end else if (step_cnt == STEP_LIMIT) begin
            steps_r <= ABANDONED;
            state   <= STORE;
          end else begin
            step_cnt <= step_cnt + STEP_ONE;
          end
        end
        STORE: begin
          if (is_last) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            state    <= IDLE;
          end else begin
            idx   <= idx + IDX_ONE;
            cur   <= next_cur;
            it_n  <= next_cur;
            it_go <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result RAM is deliberately not reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (state == STORE) mem[idx] <= steps_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/collatz_range.md
Name: collatz_range

Overview:
- Initiator for the team's Collatz iterator. It drives the iterator's go/n inputs and consumes its dout/done outputs.
- It sweeps a contiguous range of start values and measures the step count to reach 1 for each one.
- It stores each count in an internal RAM that the host reads through a synchronous read port.
- It sits between the host/register interface and one collatz iterator instance in the lab1 datapath.

Parameters:
- WIDTH, 32, width of start values and of the iterator n/dout buses.
- ADDR_W, 8, RAM address width; the range holds at most 2**ADDR_W values.
- CNT_W, 16, width of a stored step count.
- MAX_STEPS, 1000, step limit per value before the value is abandoned; must be < 2**CNT_W - 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- start_n  in  WIDTH  first value of the range; captured when start is accepted.
- count  in  ADDR_W+1  number of values to sweep, 0..2**ADDR_W; captured with start.
- busy  out  1  high from the cycle after start is accepted until the sweep ends.
- finished  out  1  one-cycle pulse on the cycle busy falls.
- it_go  out  1  to iterator: load it_n this cycle.
- it_n  out  WIDTH  to iterator: value to load.
- it_dout  in  WIDTH  from iterator: current sequence value.
- it_done  in  1  from iterator: high while it_dout == 1.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  CNT_W  RAM word at rd_addr, registered with 1-cycle latency.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - busy, finished and it_go are 0.
  - it_n and rd_data are 0.
  - Internal value register, index and step counter are 0.
  - RAM contents are not reset; they are undefined until written.
- Iterator contract:
  - it_go high in cycle t loads it_n.
  - From cycle t+1 the iterator presents one sequence value per cycle on it_dout.
  - it_done is valid in the same cycle as the value it describes.
- State machine:
  - IDLE:
    - On start=1 with count!=0: capture start_n into cur, clear idx, then go to LOAD; busy rises next cycle.
    - On start=1 with count==0: stay in IDLE and pulse finished for one cycle; busy stays 0 and nothing is written.
  - LOAD (1 cycle): it_go=1, it_n=cur, step counter cleared. Next state is RUN.
  - RUN: each cycle, sample it_done.
    - it_done=1: go to STORE with steps = current counter.
    - it_done=0: counter increments.
    - Counter reaches MAX_STEPS without done: go to STORE with steps = all-ones (2**CNT_W-1, the abandoned marker).
  - STORE (1 cycle):
    - RAM[idx] <= steps.
    - If idx == count-1: go to IDLE; busy falls and finished pulses in that transition cycle.
    - Otherwise: idx++, cur++, go to LOAD.
- it_go is high only in LOAD; it_n holds its last value otherwise.
- Step semantics: steps = number of iterator cycles with it_done=0 after the load. n=1 gives 0; n=2 gives 1.
- Arithmetic:
  - cur increments modulo 2**WIDTH; wrap-around is not flagged.
  - n=0 never reaches done and is stored as all-ones after MAX_STEPS.
- Per-value latency: steps + 3 cycles (LOAD, RUN up to done, STORE).
- start while busy is ignored; captured parameters are unaffected.
- Read port:
  - rd_data <= RAM[rd_addr] every cycle, including during a sweep.
  - A read of the address written in the same cycle returns the old word (read-before-write).
- reset_n asserted mid-sweep: immediate return to IDLE with all outputs at reset values. Words already written stay in the RAM; the sweep does not resume.

Test Plan:
- Reset, start=1, start_n=1, count=8 -> RAM[0..7] = 0,1,7,2,5,8,16,3; busy high for exactly sum(steps+3)=66 cycles; single finished pulse.
- start_n=27, count=1 -> RAM[0]=111; it_go is high for exactly one cycle with it_n=27.
- start_n=0, count=1 -> RAM[0]=16'hFFFF after MAX_STEPS cycles in RUN; sweep still finishes normally.
- count=0 -> finished pulses one cycle after start; busy never rises; RAM is unchanged.
- Second start pulse while busy with start_n=100, count=4 -> ignored; first sweep's results are unchanged.
- reset_n low mid-sweep, release, then new sweep start_n=5, count=2 -> RAM[0]=5, RAM[1]=8. rd_data equals RAM[rd_addr] one cycle after rd_addr changes.
